// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier: one multiplier bit per clock, start/done/busy handshake.
// Define SEQ_MULT_SIGNED_EN to treat A and B as two's complement (sign-magnitude around the unsigned core).
module seq_mult_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     result_q, result_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, done_q;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [PW-1:0]     acc_sum, acc_fin;
  logic              operand_zero;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes as WIDTH-bit unsigned; the most negative value maps onto 2^(WIDTH-1).
  assign a_mag   = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_mag   = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  assign acc_fin = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
`else
  assign a_mag   = A;
  assign b_mag   = B;
  assign acc_fin = acc_sum;
`endif

  assign operand_zero = (A == '0) || (B == '0);
  assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
`endif
          if (operand_zero) begin
            state_d  = ST_DONE;
            result_d = '0;
          end else begin
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_fin;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: driver pushes expected products and done cycles,
// a negedge monitor pops and compares; busy and result stability are checked every cycle.
module tb_seq_mult_param;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [PW-1:0] result;
  logic          done;
  logic          busy;

  seq_mult_param #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] res;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;
  int            busy_lo = -1;
  int            busy_hi = -2;
  int            ready_edge = 0;
  logic [PW-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(bit ok, string name, longint act, longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] model(logic [W-1:0] a, logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p  = sa * sb;
`else
    longint p  = longint'(a) * longint'(b);
`endif
    return PW'(p);
  endfunction

  // Waits until the DUT can accept, toggling start/A/B as noise during RUN, then issues one op.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int gap, output int e_out);
    int lat;
    while (cyc + 1 < ready_edge + gap) begin
      start = (cyc + 1 < ready_edge) ? 1'($urandom_range(0, 1)) : 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b1;
    A     = a;
    B     = b;
    e_out = cyc + 1;
    lat   = (a == '0 || b == '0) ? 0 : int'(W);
    sb_q.push_back('{model(a, b), e_out + lat});
    if (lat != 0) begin
      busy_lo = e_out;
      busy_hi = e_out + int'(W) - 1;
    end
    ready_edge = e_out + lat + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(busy == ((cyc >= busy_lo) && (cyc <= busy_hi)), "busy",
            longint'(busy), longint'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (done) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_done", longint'(result), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check(cyc == e.due, "done_cycle", cyc, e.due);
          check(result == e.res, "result", longint'(result), longint'(e.res));
          last_exp = e.res;
        end
      end else begin
        check(result == last_exp, "result_hold", longint'(result), longint'(last_exp));
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
          check(1'b0, "done_timeout", cyc, sb_q[0].due);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int e;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(result == '0, "reset_result", longint'(result), 0);
    check(done == 1'b0, "reset_done", longint'(done), 0);
    check(busy == 1'b0, "reset_busy", longint'(busy), 0);
    reset      = 1'b1;
    ready_edge = cyc + 1;
    mon_en     = 1'b1;

    issue(W'(13), W'(5), 1, e);
    issue('1, '1, 0, e);
    issue(W'(21), W'(1), 2, e);
    issue(W'(21), W'(5), 0, e);
    issue(W'(70), W'(0), 1, e);
    issue(W'(0), W'(9), 0, e);
    issue(W'(7), W'(3), 5, e);
`ifdef SEQ_MULT_SIGNED_EN
    issue(W'(-3), W'(5), 0, e);
    issue({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1, e);
    issue({1'b0, {(W-1){1'b1}}}, '1, 0, e);
`endif
    for (int i = 0; i < 60; i++) begin
      issue(pick_operand(), pick_operand(), int'($urandom_range(0, 2)), e);
    end

    // Asynchronous reset three cycles into RUN, after a nonzero product is on result.
    issue('1, '1, 0, e);
    issue(W'(82), W'(4), 0, e);
    while (cyc < e + 3) begin
      @(posedge clk); #1;
    end
    #1;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check(result == '0, "async_rst_result", longint'(result), 0);
    check(done == 1'b0, "async_rst_done", longint'(done), 0);
    check(busy == 1'b0, "async_rst_busy", longint'(busy), 0);
    sb_q.delete();
    busy_lo  = -1;
    busy_hi  = -2;
    last_exp = '0;
    @(posedge clk); #1;
    reset      = 1'b1;
    ready_edge = cyc + 1;
    mon_en     = 1'b1;
    issue(W'(82), W'(4), 1, e);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) check(1'b0, "drain_timeout", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
